charmap_dma: RTL and testbench

CHARMAP_DMA -- requirements
Module: charmap_dma

---
 rtl/charmap_dma_pkg.sv | 48 ++++
 rtl/charmap_dma.sv | 212 +++++++++++++++++++++
 tb/tb_charmap_dma.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/charmap_dma_pkg.sv
// Shared definitions for the character-plane DMA: register offsets, CTRL
// bit positions, plane-mask bits and the transfer state encoding.
package charmap_dma_pkg;

  // Register window offsets (cpu_addr[2:0])
  localparam logic [2:0] REG_DST_LO = 3'd0;
  localparam logic [2:0] REG_DST_HI = 3'd1;
  localparam logic [2:0] REG_SRC_LO = 3'd2;
  localparam logic [2:0] REG_SRC_HI = 3'd3;
  localparam logic [2:0] REG_LEN_LO = 3'd4;
  localparam logic [2:0] REG_LEN_HI = 3'd5;
  localparam logic [2:0] REG_FILL   = 3'd6;
  localparam logic [2:0] REG_CTRL   = 3'd7;

  // CTRL bit positions
  localparam int CTRL_START    = 0;
  localparam int CTRL_MODE     = 1;
  localparam int CTRL_MASK_LSB = 2;
  localparam int CTRL_MASK_MSB = 4;
  localparam int CTRL_ABORT    = 7;

  // Plane-mask / ram_we bit assignments
  localparam int PLANE_CH = 0;
  localparam int PLANE_FG = 1;
  localparam int PLANE_BG = 2;

  // Longest transfer: one full 2048-cell plane
  localparam logic [11:0] LEN_MAX = 12'd2048;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_CP_RD  = 3'd2,
    ST_CP_LAT = 3'd3,
    ST_CP_WR  = 3'd4
  } state_t;

  // A copy moves a single plane: the lowest plane selected in the mask.
  function automatic logic [2:0] lowest_plane(input logic [2:0] mask);
    logic [2:0] sel;
    sel = 3'b000;
    if (mask[PLANE_CH])      sel[PLANE_CH] = 1'b1;
    else if (mask[PLANE_FG]) sel[PLANE_FG] = 1'b1;
    else if (mask[PLANE_BG]) sel[PLANE_BG] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/charmap_dma.sv
// Character-plane DMA: CPU register window plus a fill/copy engine that
// borrows the shared RAM port whenever the CPU is not using it.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no transfer; waiting for START
// ST_FILL   | writing FILL to DST+i on every masked plane
// ST_CP_RD  | presenting SRC+i to the copy plane
// ST_CP_LAT | RAM read latency; ram_q captured at the end of this cycle
// ST_CP_WR  | writing the captured byte to DST+i
module charmap_dma
  import charmap_dma_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              reg_cs,
  input  logic [2:0]        reg_addr,
  input  logic              cpu_wr_n,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_ram_req,
  output logic [7:0]        reg_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [2:0]        ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_q,
  output logic              dma_own,
  output logic              busy,
  output logic              done_pulse
);

  logic              wr_low_q;
  logic [10:0]       dst_r;
  logic [10:0]       src_r;
  logic [11:0]       len_r;
  logic [7:0]        fill_r;
  logic              mode_r;
  logic [2:0]        mask_r;

  state_t            state;
  logic [11:0]       cnt;
  logic [ADDR_W-1:0] src_p;
  logic [ADDR_W-1:0] dst_p;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [2:0]        we_q;
  logic              own_q;
  logic [2:0]        plane_q;

  logic              commit;
  logic              start_cmd;
  logic              abort_cmd;
  logic [2:0]        new_mask;
  logic              new_mode;
  logic [11:0]       eff_len;
  logic              last_step;
  logic              to_idle;

  // A strobe held low for several clocks commits only on its first low cycle.
  assign commit    = reg_cs & ~cpu_wr_n & ~wr_low_q;
  assign start_cmd = commit & (reg_addr == REG_CTRL) & cpu_dout[CTRL_START] & ~busy;
  assign abort_cmd = commit & (reg_addr == REG_CTRL) & cpu_dout[CTRL_ABORT] & busy;
  assign new_mask  = cpu_dout[CTRL_MASK_MSB:CTRL_MASK_LSB];
  assign new_mode  = cpu_dout[CTRL_MODE];
  assign eff_len   = (len_r > LEN_MAX) ? LEN_MAX : len_r;

  assign last_step = ((state == ST_FILL) || (state == ST_CP_WR)) && !cpu_ram_req && (cnt == 12'd1);
  assign to_idle   = abort_cmd | last_step;

  // The CPU always wins the shared port; reset also blocks any write in its own cycle.
  assign dma_own   = own_q & ~cpu_ram_req & ~reset;
  assign ram_we    = we_q & {3{~cpu_ram_req & ~reset}};
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  // Register file: strobe history and configuration, frozen while a transfer runs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_low_q <= 1'b0;
      dst_r    <= '0;
      src_r    <= '0;
      len_r    <= '0;
      fill_r   <= '0;
      mode_r   <= 1'b0;
      mask_r   <= '0;
    end else begin
      wr_low_q <= ~cpu_wr_n;
      if (commit && !busy) begin
        case (reg_addr)
          REG_DST_LO: dst_r[7:0]   <= cpu_dout;
          REG_DST_HI: dst_r[10:8]  <= cpu_dout[2:0];
          REG_SRC_LO: src_r[7:0]   <= cpu_dout;
          REG_SRC_HI: src_r[10:8]  <= cpu_dout[2:0];
          REG_LEN_LO: len_r[7:0]   <= cpu_dout;
          REG_LEN_HI: len_r[11:8]  <= cpu_dout[3:0];
          REG_FILL:   fill_r       <= cpu_dout;
          REG_CTRL: begin
            mode_r <= new_mode;
            mask_r <= new_mask;
          end
          default: ;
        endcase
      end
    end
  end

  // Registered readback of the selected offset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      reg_dout <= '0;
    end else begin
      case (reg_addr)
        REG_DST_LO: reg_dout <= dst_r[7:0];
        REG_DST_HI: reg_dout <= {5'b0, dst_r[10:8]};
        REG_SRC_LO: reg_dout <= src_r[7:0];
        REG_SRC_HI: reg_dout <= {5'b0, src_r[10:8]};
        REG_LEN_LO: reg_dout <= len_r[7:0];
        REG_LEN_HI: reg_dout <= {4'b0, len_r[11:8]};
        REG_FILL:   reg_dout <= fill_r;
        REG_CTRL:   reg_dout <= {busy, 2'b00, mask_r, mode_r, 1'b0};
        default:    reg_dout <= '0;
      endcase
    end
  end

  // Transfer engine; addr/data/we for the next cycle are registered on each transition.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      cnt        <= '0;
      src_p      <= '0;
      dst_p      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= '0;
      own_q      <= 1'b0;
      plane_q    <= '0;
    end else begin
      done_pulse <= 1'b0;
      if (to_idle) begin
        state      <= ST_IDLE;
        busy       <= 1'b0;
        done_pulse <= 1'b1;
        addr_q     <= '0;
        wdata_q    <= '0;
        we_q       <= '0;
        own_q      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_cmd) begin
              if ((eff_len == 12'd0) || (new_mask == 3'b000)) begin
                done_pulse <= 1'b1;
              end else begin
                busy  <= 1'b1;
                cnt   <= eff_len;
                src_p <= ADDR_W'(src_r);
                dst_p <= ADDR_W'(dst_r);
                own_q <= 1'b1;
                if (!new_mode) begin
                  state   <= ST_FILL;
                  addr_q  <= ADDR_W'(dst_r);
                  wdata_q <= fill_r;
                  we_q    <= new_mask;
                end else begin
                  state   <= ST_CP_RD;
                  addr_q  <= ADDR_W'(src_r);
                  we_q    <= '0;
                  plane_q <= lowest_plane(new_mask);
                end
              end
            end
          end
          ST_FILL: begin
            if (!cpu_ram_req) begin
              cnt    <= cnt - 1'b1;
              addr_q <= addr_q + 1'b1;
            end
          end
          ST_CP_RD: begin
            if (!cpu_ram_req) begin
              state <= ST_CP_LAT;
              own_q <= 1'b0;
            end
          end
          ST_CP_LAT: begin
            state   <= ST_CP_WR;
            wdata_q <= ram_q;
            addr_q  <= dst_p;
            we_q    <= plane_q;
            own_q   <= 1'b1;
          end
          ST_CP_WR: begin
            if (!cpu_ram_req) begin
              state  <= ST_CP_RD;
              cnt    <= cnt - 1'b1;
              src_p  <= src_p + 1'b1;
              dst_p  <= dst_p + 1'b1;
              addr_q <= src_p + 1'b1;
              we_q   <= '0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_charmap_dma.sv
// Directed bench for charmap_dma: register readback table, then fill, copy,
// stall, held-strobe, clamp, abort and reset sequences against a write log.
module tb_charmap_dma;

  localparam int ADDR_W = 11;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic              reg_cs = 1'b0;
  logic [2:0]        reg_addr = 3'd0;
  logic              cpu_wr_n = 1'b1;
  logic [7:0]        cpu_dout = 8'h00;
  logic              cpu_ram_req = 1'b0;
  logic [7:0]        ram_q = 8'h00;
  logic [7:0]        reg_dout;
  logic [ADDR_W-1:0] ram_addr;
  logic [2:0]        ram_we;
  logic [7:0]        ram_wdata;
  logic              dma_own;
  logic              busy;
  logic              done_pulse;

  charmap_dma #(.ADDR_W(ADDR_W)) dut (
    .clk_sys(clk_sys), .reset(reset), .reg_cs(reg_cs), .reg_addr(reg_addr),
    .cpu_wr_n(cpu_wr_n), .cpu_dout(cpu_dout), .cpu_ram_req(cpu_ram_req),
    .reg_dout(reg_dout), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_q(ram_q), .dma_own(dma_own), .busy(busy),
    .done_pulse(done_pulse)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int         c;
    logic [10:0] a;
    logic [2:0]  we;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    logic [2:0] off;
    logic [7:0] wdata;
    logic [7:0] exp;
  } reg_vec_t;

  wr_t wq[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int viol = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int commit_cyc = 0;

  // Copy-plane contents as seen through ram_q
  function automatic logic [7:0] pat(input logic [10:0] a);
    return 8'(a * 7 + 3);
  endfunction

  // One-cycle read latency RAM model
  always @(posedge clk_sys) ram_q <= pat(ram_addr);

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Log every DMA write and watch port-ownership rules
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (ram_we != 3'b000) begin
        wr_t r;
        r.c = cyc; r.a = ram_addr; r.we = ram_we; r.d = ram_wdata;
        wq.push_back(r);
        if (!dma_own) viol++;
      end
      if (cpu_ram_req && (dma_own || ram_we != 3'b000)) viol++;
      if (busy) busy_cnt++;
      if (done_pulse) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic reg_write(input logic [2:0] off, input logic [7:0] d, input int hold);
    @(posedge clk_sys); #1;
    reg_cs = 1'b1; reg_addr = off; cpu_dout = d; cpu_wr_n = 1'b0;
    commit_cyc = cyc;
    repeat (hold) @(posedge clk_sys);
    #1;
    cpu_wr_n = 1'b1; reg_cs = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] off, output logic [7:0] d);
    @(posedge clk_sys); #1;
    reg_addr = off;
    @(posedge clk_sys); #1;
    d = reg_dout;
  endtask

  task automatic program_regs(input logic [10:0] dst, input logic [10:0] src,
                              input logic [11:0] len, input logic [7:0] fill);
    reg_write(3'd0, dst[7:0], 1);
    reg_write(3'd1, {5'b0, dst[10:8]}, 1);
    reg_write(3'd2, src[7:0], 1);
    reg_write(3'd3, {5'b0, src[10:8]}, 1);
    reg_write(3'd4, len[7:0], 1);
    reg_write(3'd5, {4'b0, len[11:8]}, 1);
    reg_write(3'd6, fill, 1);
  endtask

  task automatic clear_log();
    wq.delete();
    busy_cnt = 0;
    viol = 0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check(name, done_cnt - d0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    reg_vec_t rv[10];
    logic [7:0] rd;
    logic [10:0] ea[4];
    int d0;
    int bad;
    int n;
    int a_cyc;

    rv[0] = '{3'd0, 8'hFF, 8'hFF};
    rv[1] = '{3'd1, 8'hFF, 8'h07};
    rv[2] = '{3'd2, 8'h34, 8'h34};
    rv[3] = '{3'd3, 8'hAB, 8'h03};
    rv[4] = '{3'd4, 8'h12, 8'h12};
    rv[5] = '{3'd5, 8'hF5, 8'h05};
    rv[6] = '{3'd6, 8'h41, 8'h41};
    rv[7] = '{3'd7, 8'h1E, 8'h1E};
    rv[8] = '{3'd7, 8'h9C, 8'h1C};
    rv[9] = '{3'd5, 8'h08, 8'h08};

    // Reset state
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done_pulse, 0);
    check("rst_we", ram_we, 0);
    check("rst_own", dma_own, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_reg_dout", reg_dout, 0);
    reset = 1'b0;

    // Register write / readback table
    for (int i = 0; i < 10; i++) begin
      reg_write(rv[i].off, rv[i].wdata, 1);
      reg_read(rv[i].off, rd);
      check($sformatf("reg_rb_%0d", i), rd, rv[i].exp);
    end
    check("reg_no_start_done", done_cnt, 0);

    // Fill wrapping past the top of the plane
    program_regs(11'h7FE, 11'h000, 12'd4, 8'h41);
    clear_log();
    reg_write(3'd7, 8'h0D, 1);
    wait_done(20, "fill_wrap_done");
    ea[0] = 11'h7FE; ea[1] = 11'h7FF; ea[2] = 11'h000; ea[3] = 11'h001;
    check("fill_wrap_count", wq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wq.size()) begin
        check($sformatf("fill_wrap_addr_%0d", i), wq[i].a, ea[i]);
        check($sformatf("fill_wrap_we_%0d", i), wq[i].we, 3'b011);
        check($sformatf("fill_wrap_data_%0d", i), wq[i].d, 8'h41);
        check($sformatf("fill_wrap_cyc_%0d", i), wq[i].c, commit_cyc + 1 + i);
      end
    end
    check("fill_wrap_done_cyc", done_cyc, commit_cyc + 5);
    check("fill_wrap_busy_cycles", busy_cnt, 4);
    check("fill_wrap_own_rules", viol, 0);

    // Copy, mask 110 -> fg plane only
    program_regs(11'h100, 11'h010, 12'd3, 8'h00);
    clear_log();
    reg_write(3'd7, 8'h1B, 1);
    wait_done(40, "copy_done");
    check("copy_count", wq.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < wq.size()) begin
        check($sformatf("copy_addr_%0d", i), wq[i].a, 11'h100 + i);
        check($sformatf("copy_we_%0d", i), wq[i].we, 3'b010);
        check($sformatf("copy_data_%0d", i), wq[i].d, pat(11'(16 + i)));
      end
    end
    check("copy_busy_cycles", busy_cnt, 9);
    check("copy_own_rules", viol, 0);

    // Fill with a three-cycle CPU stall after the first write
    program_regs(11'h020, 11'h000, 12'd2, 8'h77);
    clear_log();
    reg_write(3'd7, 8'h05, 1);
    @(posedge clk_sys); #1;
    cpu_ram_req = 1'b1;
    #1;
    check("stall_own", dma_own, 0);
    check("stall_we", ram_we, 0);
    repeat (3) @(posedge clk_sys);
    #1;
    cpu_ram_req = 1'b0;
    wait_done(20, "stall_done");
    check("stall_count", wq.size(), 2);
    if (wq.size() == 2) begin
      check("stall_first_cyc", wq[0].c, commit_cyc + 1);
      check("stall_gap", wq[1].c - wq[0].c, 4);
      check("stall_second_addr", wq[1].a, 11'h021);
      check("stall_second_data", wq[1].d, 8'h77);
    end
    check("stall_own_rules", viol, 0);

    // START strobe held 5 cycles, then ignored DST and START writes mid-transfer
    program_regs(11'h200, 11'h000, 12'd20, 8'h3C);
    clear_log();
    d0 = done_cnt;
    reg_write(3'd7, 8'h11, 5);
    reg_write(3'd0, 8'h55, 1);
    reg_write(3'd7, 8'h05, 1);
    wait_done(60, "held_done");
    repeat (10) @(posedge clk_sys);
    #1;
    check("held_count", wq.size(), 20);
    check("held_single_done", done_cnt - d0, 1);
    bad = 0;
    for (int i = 0; i < wq.size(); i++) begin
      if (wq[i].a !== 11'(12'h200 + i) || wq[i].we !== 3'b100 || wq[i].d !== 8'h3C) bad++;
    end
    check("held_write_seq", bad, 0);
    reg_read(3'd0, rd);
    check("held_dst_kept", rd, 8'h00);
    reg_read(3'd7, rd);
    check("held_ctrl_kept", rd, 8'h10);

    // LEN above a full plane clamps to 2048
    program_regs(11'h000, 11'h000, 12'hFFF, 8'hA5);
    clear_log();
    reg_write(3'd7, 8'h05, 1);
    wait_done(2200, "clamp_done");
    check("clamp_count", wq.size(), 2048);
    if (wq.size() > 0) check("clamp_last_addr", wq[wq.size()-1].a, 11'h7FF);
    check("clamp_own_rules", viol, 0);

    // LEN=0: no transfer, done the next cycle
    program_regs(11'h000, 11'h000, 12'd0, 8'hA5);
    clear_log();
    d0 = done_cnt;
    reg_write(3'd7, 8'h05, 1);
    repeat (3) @(posedge clk_sys);
    #1;
    check("len0_writes", wq.size(), 0);
    check("len0_done", done_cnt - d0, 1);
    check("len0_done_cyc", done_cyc, commit_cyc + 1);
    check("len0_busy", busy_cnt, 0);

    // mask=0: no transfer, done the next cycle
    program_regs(11'h000, 11'h000, 12'd5, 8'hA5);
    clear_log();
    d0 = done_cnt;
    reg_write(3'd7, 8'h01, 1);
    repeat (3) @(posedge clk_sys);
    #1;
    check("mask0_writes", wq.size(), 0);
    check("mask0_done", done_cnt - d0, 1);
    check("mask0_busy", busy_cnt, 0);

    // ABORT after 10 fill writes
    program_regs(11'h300, 11'h000, 12'd100, 8'h11);
    clear_log();
    reg_write(3'd7, 8'h05, 1);
    n = 0;
    while (wq.size() < 10 && n < 50) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check("abort_reached_10", wq.size() >= 10, 1);
    reg_write(3'd7, 8'h80, 1);
    a_cyc = commit_cyc;
    repeat (5) @(posedge clk_sys);
    #1;
    check("abort_count", wq.size(), 12);
    if (wq.size() > 0) check("abort_last_cyc", wq[wq.size()-1].c, a_cyc);
    check("abort_done_cyc", done_cyc, a_cyc + 1);
    check("abort_busy", busy, 0);

    // Reset in the middle of a copy write cycle
    program_regs(11'h400, 11'h000, 12'd50, 8'h00);
    clear_log();
    reg_write(3'd7, 8'h0B, 1);
    repeat (5) @(posedge clk_sys);
    #1;
    check("rstmid_in_write", ram_we, 3'b010);
    reset = 1'b1;
    #1;
    check("rstmid_no_we", ram_we, 0);
    check("rstmid_no_own", dma_own, 0);
    @(posedge clk_sys); #1;
    check("rstmid_ctl", {busy, done_pulse, dma_own, ram_we}, 0);
    check("rstmid_addr", ram_addr, 0);
    check("rstmid_data", {ram_wdata, reg_dout}, 0);
    reset = 1'b0;
    reg_read(3'd4, rd);
    check("rstmid_len_cleared", rd, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
